// File: rtl/pal_fuse_loader.sv
// pal_fuse_loader: serial fuse bitstream loader for the PAL fabric.
// Bits shift into a shadow register over cfg_valid/cfg_ready and the full
// word is committed atomically to config_out, so the planes keep running on
// the previous configuration while a new one loads.
// Optional feature macro: PAL_FUSE_PARITY_EN (appends one even-parity bit to
// every load; a bad parity aborts the commit and raises sticky cfg_error).
module pal_fuse_loader #(
  parameter int CFG_LEN   = 64,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [CFG_LEN-1:0] config_out,
  output logic               config_valid,
  output logic               load_done,
  output logic               busy,
  output logic               cfg_error
);

  localparam int CW = $clog2(CFG_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [CFG_LEN-1:0] shadow, shadow_shifted;
  logic [CW-1:0]      cnt;
  logic               restart;
  logic               shift_en;
  logic               last_bit;

  // Restart beats a coincident data bit, so a bit is taken only without cfg_start.
  assign shift_en = (state == SHIFT) && cfg_valid && !cfg_start;
  assign last_bit = (cnt == CW'(CFG_LEN - 1));

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shadow_shifted = {shadow[CFG_LEN-2:0], cfg_data};
    end else begin : g_lsb
      assign shadow_shifted = {cfg_data, shadow[CFG_LEN-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          restart   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_start) begin
          restart = 1'b1;
        end else if (cfg_valid && last_bit) begin
`ifdef PAL_FUSE_PARITY_EN
          state_nxt = CHECK;
`else
          state_nxt = COMMIT;
`endif
        end
      end
      CHECK: begin
`ifdef PAL_FUSE_PARITY_EN
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_start) begin
          restart   = 1'b1;
          state_nxt = SHIFT;
        end else if (cfg_valid) begin
          state_nxt = (^{shadow, cfg_data}) ? IDLE : COMMIT;
        end
`else
        state_nxt = IDLE;
`endif
      end
      COMMIT: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow/counter datapath and the atomic commit of the fuse vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      cnt          <= '0;
      config_out   <= '0;
      config_valid <= 1'b0;
    end else begin
      if (restart) begin
        shadow <= '0;
        cnt    <= '0;
      end else if (shift_en) begin
        shadow <= shadow_shifted;
        cnt    <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        config_out   <= shadow;
        config_valid <= 1'b1;
      end
    end
  end

`ifdef PAL_FUSE_PARITY_EN
  // Sticky parity error: set on a bad parity bit, cleared by the next start.
  always_ff @(posedge clk) begin
    if (rst)
      cfg_error <= 1'b0;
    else if (restart)
      cfg_error <= 1'b0;
    else if (state == CHECK && cfg_valid && ^{shadow, cfg_data})
      cfg_error <= 1'b1;
  end
`else
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_pal_fuse_loader.sv
// Testbench for pal_fuse_loader: two instances (MSB-first and LSB-first) share
// one randomized serial stream; expected commits go to a queue that a
// negedge monitor pops on every load_done.
module tb_pal_fuse_loader;
  localparam int N = 8;

  logic clk = 0, rst = 1, cfg_start = 0, cfg_data = 0, cfg_valid = 0;
  logic         rdy0, rdy1, cv0, cv1, ld0, ld1, busy0, busy1, err0, err1;
  logic [N-1:0] co0, co1;

  pal_fuse_loader #(.CFG_LEN(N), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0), .config_out(co0),
    .config_valid(cv0), .load_done(ld0), .busy(busy0), .cfg_error(err0));

  pal_fuse_loader #(.CFG_LEN(N), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1), .config_out(co1),
    .config_valid(cv1), .load_done(ld1), .busy(busy1), .cfg_error(err1));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] w_msb;
    logic [N-1:0] w_lsb;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0, fails = 0, cyc = 0;
  bit           mon_en = 0;
  logic [N-1:0] exp_co0 = '0, exp_co1 = '0;
  logic         exp_cv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: committed outputs must match the model every cycle; a load_done
  // pops the next expected word, which must appear on the following edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("config_out_msb", 64'(co0), 64'(exp_co0));
      chk("config_out_lsb", 64'(co1), 64'(exp_co1));
      chk("config_valid", 64'({cv0, cv1}), 64'({exp_cv, exp_cv}));
      chk("load_done_pair", 64'(ld1), 64'(ld0));
      if (rst) begin
        exp_co0 = '0; exp_co1 = '0; exp_cv = 1'b0;
      end else if (ld0) begin
        if (sb.size() == 0) begin
          chk("unexpected_load_done", 64'(ld0), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_latency", 64'(cyc), 64'(e.cyc + 1));
          exp_co0 = e.w_msb; exp_co1 = e.w_lsb; exp_cv = 1'b1;
        end
      end
    end
  end

  // One drive slot: wait for the edge, then settle inputs #1 later.
  task automatic slot(input logic st, input logic v, input logic d);
    @(posedge clk); #1;
    cfg_start = st; cfg_valid = v; cfg_data = d;
  endtask

  // Send a load of word w (w[N-1] first on the wire). nbits < N leaves the
  // load unfinished (to be aborted). gap: 0 none, 1 every other, 2 random.
  task automatic send(input logic [N-1:0] w, input int nbits, input int gap, input bit bad_par);
    exp_t e;
    logic par;
    slot(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < nbits; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
        slot(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      chk("cfg_ready_shift", 64'({rdy0, rdy1, busy0, busy1}), 64'(4'hF));
      cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = w[N-1-i];
      if (i == N - 1) begin
        e.w_msb = w;
        for (int k = 0; k < N; k++) e.w_lsb[k] = w[N-1-k];
        e.cyc = cyc;
`ifdef PAL_FUSE_PARITY_EN
        par = (^w) ^ bad_par;
        @(posedge clk); #1;
        chk("cfg_ready_check", 64'({rdy0, rdy1}), 64'(2'b11));
        cfg_valid = 1'b1; cfg_data = par;
        e.cyc = cyc;
        if (!bad_par) sb.push_back(e);
`else
        par = bad_par;
        sb.push_back(e);
`endif
      end
    end
    if (nbits == N) begin
      slot(1'b0, 1'b0, 1'b0);
      chk("cfg_ready_after", 64'({rdy0, rdy1, busy0, busy1}), 64'(0));
`ifdef PAL_FUSE_PARITY_EN
      chk("cfg_error", 64'({err0, err1}), bad_par ? 64'(2'b11) : 64'(0));
`else
      chk("cfg_error_tied", 64'({err0, err1}), 64'(0));
`endif
      slot(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expected commits pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'({rdy0, busy0, ld0, cv0, err0, co0}), 64'(0));
    mon_en = 1;
    slot(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    slot(1'b0, 1'b1, 1'b1);          // cfg_valid in IDLE must be ignored
    chk("idle_ready", 64'({rdy0, rdy1}), 64'(0));

    // Plain load 1,0,1,0,0,0,0,0 on consecutive cycles.
    send(8'hA0, N, 0, 1'b0);
    chk("plan_msb_A0", 64'(co0), 64'(8'hA0));
    chk("plan_lsb_05", 64'(co1), 64'(8'h05));

    // Gappy load: old value held until the commit edge.
    send(8'h55, N, 1, 1'b0);
    chk("plan_gap_55", 64'(co0), 64'(8'h55));

    // Abort after 4 bits, then a full load.
    send(8'hAA, 4, 0, 1'b0);
    send(8'h0F, N, 0, 1'b0);
    chk("plan_abort_0F", 64'(co0), 64'(8'h0F));

`ifdef PAL_FUSE_PARITY_EN
    send(8'hA0, N, 0, 1'b0);
    chk("parity_good", 64'(co0), 64'(8'hA0));
    send(8'h3C, N, 0, 1'b1);
    chk("parity_bad_hold", 64'(co0), 64'(8'hA0));
    slot(1'b1, 1'b0, 1'b0);
    slot(1'b0, 1'b0, 1'b0);
    chk("parity_err_clear", 64'(err0), 64'(0));
    send(8'h55, N, 0, 1'b0);
`else
    send(8'h55, N, 0, 1'b0);
`endif

    // Reset 5 bits into a load.
    send(8'hC3, 5, 0, 1'b0);
    slot(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    slot(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_midload", 64'({co0, cv0, rdy0, busy0}), 64'(0));

    // Randomized loads: gaps, aborts and (when enabled) parity faults.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] w;
      w = N'($urandom);
      if ($urandom_range(0, 4) == 0)
        send(N'($urandom), $urandom_range(1, N - 1), 2, 1'b0);
      send(w, N, 2, ($urandom_range(0, 3) == 0));
    end

    repeat (4) slot(1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pal_fuse_loader.md
Name: pal_fuse_loader

Overview:
- Serial configuration loader for the PAL fabric.
- Shifts a fuse bitstream in over a valid/ready handshake and holds it in a shadow register.
- Commits the complete word atomically to a parallel fuse vector that drives the AND/OR planes feeding the REDUCE stages.
- The committed vector is double-buffered, so the array keeps running on the old configuration while a new one loads.

Parameters:
- CFG_LEN, 64, number of fuse bits in one configuration word; legal range >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in config_out[CFG_LEN-1]; 0 = first bit lands in config_out[0].

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_start  input  1  single-cycle request to begin a new load.
- cfg_data  input  1  serial fuse bit.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle.
- config_out  output  CFG_LEN  committed fuse vector to the planes.
- config_valid  output  1  config_out holds at least one committed word.
- load_done  output  1  one-cycle pulse on commit.
- busy  output  1  high while in SHIFT or CHECK.
- cfg_error  output  1  sticky parity error (optional feature only).

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, config_out=0, config_valid=0, load_done=0, busy=0, cfg_ready=0, cfg_error=0, shadow=0, bit counter=0.
- Counter width: $clog2(CFG_LEN+1) bits; counts accepted bits 0..CFG_LEN and never wraps.
- States: IDLE, SHIFT, CHECK, COMMIT.
- IDLE:
  - cfg_ready=0; cfg_valid is ignored.
  - cfg_start=1 -> SHIFT next cycle; counter and shadow cleared; cfg_error cleared.
- SHIFT:
  - cfg_ready=1 and busy=1.
  - A bit is accepted only when cfg_valid && cfg_ready.
  - MSB_FIRST=1: shadow <= {shadow[CFG_LEN-2:0], cfg_data}.
  - MSB_FIRST=0: shadow <= {cfg_data, shadow[CFG_LEN-1:1]}.
  - Gaps (cfg_valid=0) hold all state indefinitely.
  - When the accepted bit makes counter == CFG_LEN, next state is CHECK (feature on) or COMMIT (feature off).
- CHECK: feature-dependent; see Optional Feature.
- COMMIT (one cycle):
  - config_out <= shadow; config_valid <= 1; load_done=1 for exactly this cycle.
  - cfg_ready=0; busy=0; returns to IDLE.
- Latency: config_out updates on the first rising edge after the COMMIT cycle is entered, i.e. 2 cycles after the final bit handshake (feature off).
- config_out changes only in COMMIT; it is never partially updated.
- cfg_start while in SHIFT or CHECK aborts the load:
  - shadow and counter cleared; state stays or returns to SHIFT.
  - config_out and config_valid unchanged; no load_done.
- cfg_start in COMMIT is ignored.
- cfg_start coincident with an accepted bit in SHIFT: restart wins; the bit is discarded.
- rst mid-load returns everything to reset values, including config_out.
- config_valid, once set, stays 1 until rst.

Optional Feature:
- Macro: PAL_FUSE_PARITY_EN.
- Defined:
  - After CFG_LEN data bits, the loader enters CHECK with cfg_ready=1 and accepts one extra even-parity bit.
  - XOR of the CFG_LEN data bits and the parity bit == 0 -> COMMIT.
  - Otherwise -> IDLE without commit; cfg_error set and held until the next cfg_start or rst; config_out unchanged.
  - CHECK waits indefinitely for cfg_valid.
- Undefined:
  - CHECK state is unreachable.
  - cfg_error is tied to 0.
  - Exactly CFG_LEN bits are accepted per load.

Test Plan:
- CFG_LEN=8, MSB_FIRST=1: cfg_start, then bits 1,0,1,0,0,0,0,0 on consecutive cycles -> config_out=8'hA0 two cycles after the last bit; load_done high one cycle; config_valid=1.
- Load 8'h55 with cfg_valid low every other cycle -> cfg_ready high throughout SHIFT; config_out goes from 8'hA0 to 8'h55 only at commit, never an intermediate value.
- Start loading 8'hAA, then assert cfg_start after 4 bits and send a full 8'h0F -> config_out=8'h0F; only one load_done pulse.
- Assert rst after 5 bits of a load with config_out=8'h55 -> next cycle config_out=0, config_valid=0, state IDLE, cfg_ready=0.
- MSB_FIRST=0, send 1,0,1,0,0,0,0,0 -> config_out=8'h05.
- PAL_FUSE_PARITY_EN defined, data 8'hA0:
  - Parity bit 0 -> commit, config_out=8'hA0.
  - Parity bit 1 -> cfg_error=1, no load_done, config_out retains its previous value.
